// File: rtl/blood_pkg.sv
// Shared constants, state encoding and origin clamp helper
// for the blood-splash sprite renderer.
package blood_pkg;

    localparam int SPRITE_W = 64;
    localparam int SPRITE_H = 64;
    localparam int COLOR_W  = 12;
    localparam int COORD_W  = 10;
    localparam int CLAMP_W  = COORD_W + 1;

    localparam logic [COLOR_W-1:0] KEY_COLOR = 12'h000;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        BLINK
    } state_t;

    // Centre the sprite on c; negative origins pin to 0, large ones to lim.
    function automatic logic [COORD_W-1:0] clamp_origin(
        input logic [COORD_W-1:0] c,
        input logic [COORD_W-1:0] lim
    );
        logic signed [CLAMP_W-1:0] s;
        s = $signed({1'b0, c}) - $signed(CLAMP_W'(SPRITE_W / 2));
        if (s < 0)
            return '0;
        else if (s > $signed({1'b0, lim}))
            return lim;
        else
            return s[COORD_W-1:0];
    endfunction

endpackage

// File: rtl/splash_anim_fsm.sv
// Hit latch and frame-paced show/blink animation control.
// Origin changes only on frame_tick so a frame never tears.
module splash_anim_fsm
    import blood_pkg::*;
#(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int HOLD_FRAMES  = 30,
    parameter int BLINK_FRAMES = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               frame_tick,
    input  logic               hit,
    input  logic [COORD_W-1:0] hit_x,
    input  logic [COORD_W-1:0] hit_y,
    output logic [COORD_W-1:0] ox,
    output logic [COORD_W-1:0] oy,
    output logic               vis,
    output logic               busy
);

    localparam int MAX_F = (HOLD_FRAMES > BLINK_FRAMES) ? HOLD_FRAMES : BLINK_FRAMES;
    localparam int CNT_W = ($clog2(MAX_F) < 3) ? 3 : $clog2(MAX_F);

    localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(HOLD_FRAMES - 1);
    localparam logic [CNT_W-1:0]   BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [COORD_W-1:0] X_LIM      = COORD_W'(H_ACTIVE - SPRITE_W);
    localparam logic [COORD_W-1:0] Y_LIM      = COORD_W'(V_ACTIVE - SPRITE_H);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [COORD_W-1:0] ox_n, oy_n;
    logic [COORD_W-1:0] px, py, px_n, py_n;
    logic               pend, pend_n;

    // State, frame counter, active and pending origin registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            ox    <= '0;
            oy    <= '0;
            px    <= '0;
            py    <= '0;
            pend  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            ox    <= ox_n;
            oy    <= oy_n;
            px    <= px_n;
            py    <= py_n;
            pend  <= pend_n;
        end
    end

    // Frame-tick sequencing; a hit in the same cycle re-arms pending
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ox_n    = ox;
        oy_n    = oy;
        px_n    = px;
        py_n    = py;
        pend_n  = pend;
        if (frame_tick) begin
            if (pend) begin
                ox_n    = px;
                oy_n    = py;
                pend_n  = 1'b0;
                state_n = SHOW;
                cnt_n   = '0;
            end else begin
                unique case (state)
                    IDLE: ;
                    SHOW: begin
                        if (cnt == HOLD_LAST) begin
                            state_n = BLINK;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt + 1'b1;
                        end
                    end
                    BLINK: begin
                        if (cnt == BLINK_LAST) begin
                            state_n = IDLE;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
        if (hit) begin
            px_n   = clamp_origin(hit_x, X_LIM);
            py_n   = clamp_origin(hit_y, Y_LIM);
            pend_n = 1'b1;
        end
    end

    // Blink alternates 4 frames on, 4 frames off
    always_comb begin
        vis  = (state == SHOW) | ((state == BLINK) & ~cnt[2]);
        busy = (state != IDLE) | pend;
    end

endmodule

// File: rtl/blood_splash_renderer.sv
// Blood-splash sprite address generator and keyed compositor.
// Output lags x/y/video_on by 2 clocks to cover the ROM read.
module blood_splash_renderer
    import blood_pkg::*;
#(
    parameter int                 H_ACTIVE     = 640,
    parameter int                 V_ACTIVE     = 480,
    parameter int                 HOLD_FRAMES  = 30,
    parameter int                 BLINK_FRAMES = 32,
    parameter logic [COLOR_W-1:0] KEY_COLOR    = blood_pkg::KEY_COLOR
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic               video_on,
    input  logic               frame_tick,
    input  logic               hit,
    input  logic [COORD_W-1:0] hit_x,
    input  logic [COORD_W-1:0] hit_y,
    output logic [5:0]         rom_row,
    output logic [5:0]         rom_col,
    input  logic [COLOR_W-1:0] rom_data,
    output logic               sprite_on,
    output logic [COLOR_W-1:0] rgb,
    output logic               busy
);

    logic [COORD_W-1:0] ox, oy;
    logic [COORD_W-1:0] dx, dy;
    logic               vis;
    logic               in_box;
    logic               in_box_d1;
    logic               opaque;

    splash_anim_fsm #(
        .H_ACTIVE     (H_ACTIVE),
        .V_ACTIVE     (V_ACTIVE),
        .HOLD_FRAMES  (HOLD_FRAMES),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_anim (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_tick (frame_tick),
        .hit        (hit),
        .hit_x      (hit_x),
        .hit_y      (hit_y),
        .ox         (ox),
        .oy         (oy),
        .vis        (vis),
        .busy       (busy)
    );

    // Box test and ROM address; address parks at 0 outside the sprite
    always_comb begin
        dx     = x - ox;
        dy     = y - oy;
        in_box = video_on & vis
               & (x >= ox) & (dx < COORD_W'(SPRITE_W))
               & (y >= oy) & (dy < COORD_W'(SPRITE_H));
        rom_row = in_box ? dy[5:0] : 6'd0;
        rom_col = in_box ? dx[5:0] : 6'd0;
    end

    assign opaque = in_box_d1 & (rom_data != KEY_COLOR);

    // Align the box flag with ROM data, then register keyed colour
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_box_d1 <= 1'b0;
            sprite_on <= 1'b0;
            rgb       <= '0;
        end else begin
            in_box_d1 <= in_box;
            sprite_on <= opaque;
            rgb       <= opaque ? rom_data : '0;
        end
    end

endmodule

// File: tb/tb_blood_splash_renderer.sv
// Randomised and directed bench for blood_splash_renderer
// against a frame-age reference model and a ROM model.
module tb_blood_splash_renderer;

    localparam int HOLD  = 30;
    localparam int BLINK = 32;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic        video_on = 1'b0;
    logic        frame_tick = 1'b0;
    logic        hit = 1'b0;
    logic [9:0]  hit_x = '0;
    logic [9:0]  hit_y = '0;
    logic [5:0]  rom_row, rom_col;
    logic [11:0] rom_data = '0;
    logic        sprite_on;
    logic [11:0] rgb;
    logic        busy;

    int checks = 0;
    int failures = 0;

    // Reference model: frames since origin applied, pending hit
    int   m_active = 0, m_age = 0, m_pend = 0;
    int   m_px = 0, m_py = 0, m_ox = 0, m_oy = 0;
    bit   m_prev_on = 0, m_out_on = 0;
    logic [11:0] m_prev_c = '0, m_out_c = '0;

    blood_splash_renderer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .x          (x),
        .y          (y),
        .video_on   (video_on),
        .frame_tick (frame_tick),
        .hit        (hit),
        .hit_x      (hit_x),
        .hit_y      (hit_y),
        .rom_row    (rom_row),
        .rom_col    (rom_col),
        .rom_data   (rom_data),
        .sprite_on  (sprite_on),
        .rgb        (rgb),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] rom_f(int r, int c);
        if (((r ^ c) & 7) == 0) return 12'h000;
        return 12'((r << 6) | c);
    endfunction

    always @(posedge clk) rom_data <= rom_f(int'(rom_row), int'(rom_col));

    function automatic int clampi(int v, int lim);
        v = v - 32;
        if (v < 0) return 0;
        if (v > lim) return lim;
        return v;
    endfunction

    function bit m_vis();
        if (m_active == 0) return 0;
        if (m_age < HOLD) return 1;
        return ((m_age - HOLD) % 8) < 4;
    endfunction

    function bit m_box(int xx, int yy, bit von);
        return von && m_vis() && xx >= m_ox && xx - m_ox < 64
            && yy >= m_oy && yy - m_oy < 64;
    endfunction

    task automatic chk(string n, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    initial forever begin
        bit b;
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_active = 0; m_age = 0; m_pend = 0;
            m_px = 0; m_py = 0; m_ox = 0; m_oy = 0;
            m_prev_on = 0; m_out_on = 0;
            m_prev_c = '0; m_out_c = '0;
        end else begin
            b = m_box(int'(x), int'(y), video_on);
            m_out_on = m_prev_on;
            m_out_c  = m_prev_c;
            m_prev_c = b ? rom_f(int'(y) - m_oy, int'(x) - m_ox) : 12'h000;
            m_prev_on = (m_prev_c != 12'h000);
            if (frame_tick) begin
                if (m_pend != 0) begin
                    m_ox = m_px; m_oy = m_py;
                    m_active = 1; m_age = 0;
                end else if (m_active != 0) begin
                    m_age++;
                    if (m_age >= HOLD + BLINK) m_active = 0;
                end
                m_pend = 0;
            end
            if (hit) begin
                m_pend = 1;
                m_px = clampi(int'(hit_x), 576);
                m_py = clampi(int'(hit_y), 416);
            end
        end
    end

    initial forever begin
        bit b;
        @(negedge clk);
        if (reset_n) begin
            b = m_box(int'(x), int'(y), video_on);
            chk("rom_row", int'(rom_row), b ? int'(y) - m_oy : 0);
            chk("rom_col", int'(rom_col), b ? int'(x) - m_ox : 0);
            chk("sprite_on", int'(sprite_on), int'(m_out_on));
            chk("rgb", int'(rgb), int'(m_out_c));
            chk("busy", int'(busy), (m_active != 0 || m_pend != 0) ? 1 : 0);
        end
    end

    task automatic step(int xx, int yy, bit von, bit tk, bit h, int hx, int hy);
        x = 10'(xx); y = 10'(yy); video_on = von;
        frame_tick = tk; hit = h;
        hit_x = 10'(hx); hit_y = 10'(hy);
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        hit = 1'b0;
    endtask

    task automatic pix(int xx, int yy);
        step(xx, yy, 1, 0, 0, 0, 0);
    endtask

    task automatic tick();
        step(0, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic do_hit(int hx, int hy);
        step(0, 0, 0, 0, 1, hx, hy);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        do_reset();
        chk("reset_busy", int'(busy), 0);
        chk("reset_sprite_on", int'(sprite_on), 0);

        do_hit(100, 200);
        chk("busy_pending", int'(busy), 1);
        tick();
        chk("origin_x_100", m_ox, 68);
        chk("origin_y_200", m_oy, 168);
        for (int xx = 60; xx <= 140; xx++) begin
            pix(xx, 168);
            if (xx == 68) chk("scan_col_first", int'(rom_col), 0);
            if (xx == 131) chk("scan_col_last", int'(rom_col), 63);
            if (xx == 132) chk("scan_col_past", int'(rom_col), 0);
        end
        repeat (300) pix(60 + int'($urandom_range(0, 79)), 160 + int'($urandom_range(0, 79)));

        repeat (3) pix(101, 200);
        chk("pre_reset_sprite_on", int'(sprite_on), 1);
        chk("pre_reset_rgb", int'(rgb), 12'h821);
        #1 reset_n = 1'b0;
        #1;
        chk("async_sprite_on", int'(sprite_on), 0);
        chk("async_rgb", int'(rgb), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_rom_row", int'(rom_row), 0);
        chk("async_rom_col", int'(rom_col), 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        do_hit(10, 470);
        tick();
        chk("clamp_lo_x", m_ox, 0);
        chk("clamp_hi_y", m_oy, 416);
        pix(63, 479);
        chk("clamp1_col", int'(rom_col), 63);
        chk("clamp1_row", int'(rom_row), 63);
        do_hit(635, 5);
        tick();
        chk("clamp_hi_x", m_ox, 576);
        chk("clamp_lo_y", m_oy, 0);
        pix(639, 63);
        chk("clamp2_col", int'(rom_col), 63);
        pix(575, 0);
        chk("clamp2_left", int'(rom_col), 0);

        do_reset();
        do_hit(100, 200);
        tick();
        for (int a = 0; a < 64; a++) begin
            pix(100, 200);
            if (a == 29 || a == 30 || a == 33 || a == 38)
                chk("blink_on", int'(rom_row), 32);
            if (a == 34 || a == 37 || a == 61)
                chk("blink_off", int'(rom_row), 0);
            if (a == 61) chk("busy_last_blink", int'(busy), 1);
            if (a == 62) chk("busy_idle", int'(busy), 0);
            repeat (2) pix(int'($urandom_range(60, 170)), int'($urandom_range(160, 240)));
            tick();
        end

        do_reset();
        do_hit(100, 200);
        tick();
        repeat (40) tick();
        pix(100, 200);
        chk("retrig_old_vis", int'(rom_row), 32);
        do_hit(300, 300);
        pix(100, 200);
        chk("retrig_old_kept", int'(rom_row), 32);
        pix(300, 300);
        chk("retrig_new_wait", int'(rom_row), 0);
        tick();
        pix(300, 300);
        chk("retrig_new_on", int'(rom_row), 32);
        pix(100, 200);
        chk("retrig_old_gone", int'(rom_row), 0);
        chk("retrig_origin", m_ox, 268);

        do_reset();
        step(200, 200, 1, 1, 1, 200, 200);
        chk("same_busy", int'(busy), 1);
        chk("same_no_show", int'(rom_row), 0);
        tick();
        pix(200, 200);
        chk("same_next_show", int'(rom_row), 32);
        do_hit(100, 100);
        do_hit(400, 400);
        tick();
        pix(400, 400);
        chk("two_hits_second", int'(rom_row), 32);
        pix(100, 100);
        chk("two_hits_first", int'(rom_row), 0);
        do_hit(100, 100);
        step(100, 100, 1, 1, 1, 500, 400);
        chk("same_apply_prev", int'(rom_row), 32);
        tick();
        pix(500, 400);
        chk("same_apply_next", int'(rom_col), 32);

        repeat (3000) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2)
                step(0, 0, 0, 0, 1, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
            else if (r < 7)
                tick();
            else if (r < 9)
                step(0, 0, 0, 1, 1, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
            else begin
                int xx, yy;
                if ($urandom_range(0, 1) == 1) begin
                    xx = m_ox - 8 + int'($urandom_range(0, 79));
                    yy = m_oy - 8 + int'($urandom_range(0, 79));
                end else begin
                    xx = int'($urandom_range(0, 639));
                    yy = int'($urandom_range(0, 479));
                end
                if (xx < 0) xx = 0;
                if (yy < 0) yy = 0;
                if (xx > 1023) xx = 1023;
                if (yy > 1023) yy = 1023;
                step(xx, yy, $urandom_range(0, 7) != 0, 0, 0, 0, 0);
            end
        end
        repeat (3) pix(0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
